// File: rtl/rename_map_ckpt_pkg.sv
// Rename map configuration and shared types.
// Imported by the map, its checkpoint ring and the bus interface.
package rename_pkg;

  localparam int NUM_ARCH = 16;
  localparam int NUM_PHYS = 32;
  localparam int RD_PORTS = 4;
  localparam int WR_PORTS = 2;
  localparam int NUM_CKPT = 4;

  localparam int ARCH_W = $clog2(NUM_ARCH);
  localparam int PHYS_W = $clog2(NUM_PHYS);
  localparam int CK_W   = $clog2(NUM_CKPT);

  typedef logic [ARCH_W-1:0] arch_t;
  typedef logic [PHYS_W-1:0] phys_t;
  typedef logic [CK_W-1:0]   ckpt_id_t;
  typedef logic [CK_W:0]     ckpt_cnt_t;
  typedef phys_t [NUM_ARCH-1:0] map_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < NUM_ARCH; i++) begin
      m[i] = phys_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_map_ckpt_if.sv
// Rename control <-> alias table bus.
// master = rename/branch control, slave = the map.
interface rename_map_ckpt_if;
  import rename_pkg::*;

  arch_t [RD_PORTS-1:0] rd_addr;
  phys_t [RD_PORTS-1:0] rd_data;
  logic  [WR_PORTS-1:0] wr_en;
  arch_t [WR_PORTS-1:0] wr_addr;
  phys_t [WR_PORTS-1:0] wr_data;
  logic                 ckpt_save;
  ckpt_id_t             ckpt_save_id;
  logic                 ckpt_restore;
  ckpt_id_t             ckpt_restore_id;
  logic                 ckpt_free;
  ckpt_cnt_t            ckpt_count;
  logic                 ckpt_full;
  logic                 ckpt_empty;
  logic                 restore_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output ckpt_save, ckpt_restore,
    output ckpt_restore_id, ckpt_free,
    input  rd_data, ckpt_save_id, ckpt_count,
    input  ckpt_full, ckpt_empty, restore_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  ckpt_save, ckpt_restore,
    input  ckpt_restore_id, ckpt_free,
    output rd_data, ckpt_save_id, ckpt_count,
    output ckpt_full, ckpt_empty, restore_err
  );

endinterface

// File: rtl/rename_map_ckpt_ring.sv
// Checkpoint ring pointers: head/tail/count,
// live-id check for restore and the error pulse.
module ckpt_ring
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_save,
  input  logic      i_restore,
  input  ckpt_id_t  i_restore_id,
  input  logic      i_free,
  output logic      o_save_ok,
  output logic      o_restore_ok,
  output ckpt_id_t  o_save_id,
  output ckpt_cnt_t o_count,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_err
);

  ckpt_id_t  r_head;
  ckpt_id_t  r_tail;
  ckpt_cnt_t r_cnt;
  logic      r_err;

  ckpt_id_t  w_age;
  logic      w_live;
  logic      w_full;
  ckpt_cnt_t w_cnt1;
  ckpt_id_t  w_tail1;
  logic      w_free_ok;
  logic      w_err;

  assign w_full  = (r_cnt == ckpt_cnt_t'(NUM_CKPT));
  assign w_age   = i_restore_id - r_head;
  assign w_live  = ({1'b0, w_age} < r_cnt);

  assign o_restore_ok = i_restore && w_live;
  // a valid restore squashes any save issued with it
  assign o_save_ok = i_save && !o_restore_ok
                  && (!w_full || i_free);

  // free sees the count left behind by a restore
  assign w_cnt1  = o_restore_ok ? {1'b0, w_age} : r_cnt;
  assign w_tail1 = o_restore_ok ? i_restore_id : r_tail;
  assign w_free_ok = i_free && (w_cnt1 != '0);

  assign w_err = (i_restore && !w_live)
              || (i_free && !o_restore_ok && r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_head <= r_head + ckpt_id_t'(w_free_ok);
      r_tail <= w_tail1 + ckpt_id_t'(o_save_ok);
      r_cnt  <= w_cnt1 + ckpt_cnt_t'(o_save_ok)
                       - ckpt_cnt_t'(w_free_ok);
      r_err  <= w_err;
    end
  end

  assign o_save_id = r_tail;
  assign o_count   = r_cnt;
  assign o_full    = w_full;
  assign o_empty   = (r_cnt == '0);
  assign o_err     = r_err;

endmodule

// File: rtl/rename_map_ckpt.sv
// Register alias table with a ring of map
// snapshots for branch-mispredict recovery.
module rename_map_ckpt
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rename_map_ckpt_if.slave bus
);

  map_t     r_map;
  map_t     r_snap [NUM_CKPT];
  map_t     w_map_wr;
  map_t     w_map_nxt;
  logic     w_save_ok;
  logic     w_restore_ok;
  ckpt_id_t w_save_id;

  ckpt_ring u_ring (
    .clk          (clk),
    .rst          (rst),
    .i_save       (bus.ckpt_save),
    .i_restore    (bus.ckpt_restore),
    .i_restore_id (bus.ckpt_restore_id),
    .i_free       (bus.ckpt_free),
    .o_save_ok    (w_save_ok),
    .o_restore_ok (w_restore_ok),
    .o_save_id    (w_save_id),
    .o_count      (bus.ckpt_count),
    .o_full       (bus.ckpt_full),
    .o_empty      (bus.ckpt_empty),
    .o_err        (bus.restore_err)
  );

  assign bus.ckpt_save_id = w_save_id;

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      bus.rd_data[p] = r_map[bus.rd_addr[p]];
    end
  end

  // younger port applied last so it wins on a clash
  always_comb begin
    w_map_wr = r_map;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (bus.wr_en[w]) begin
        w_map_wr[bus.wr_addr[w]] = bus.wr_data[w];
      end
    end
  end

  assign w_map_nxt = w_restore_ok
                   ? r_snap[bus.ckpt_restore_id]
                   : w_map_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_map <= identity_map();
    end else begin
      r_map <= w_map_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_save_ok) begin
      r_snap[w_save_id] <= w_map_wr;
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt.
// Linear steps, immediate-assertion checks.
module tb_rename_map_ckpt;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rename_map_ckpt_if bus ();

  rename_map_ckpt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en           = '0;
    bus.wr_addr         = '0;
    bus.wr_data         = '0;
    bus.ckpt_save       = 1'b0;
    bus.ckpt_restore    = 1'b0;
    bus.ckpt_restore_id = '0;
    bus.ckpt_free       = 1'b0;
  endtask

  task automatic setrd(input int a0, input int a1,
                       input int a2, input int a3);
    bus.rd_addr[0] = arch_t'(a0);
    bus.rd_addr[1] = arch_t'(a1);
    bus.rd_addr[2] = arch_t'(a2);
    bus.rd_addr[3] = arch_t'(a3);
  endtask

  task automatic status(input string tag, input int cnt,
                        input int sid, input int err);
    chk({tag, "_cnt"},  32'(bus.ckpt_count), cnt);
    chk({tag, "_sid"},  32'(bus.ckpt_save_id), sid);
    chk({tag, "_err"},  32'(bus.restore_err), err);
  endtask

  initial begin
    idle();
    setrd(0, 5, 10, 15);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_rd0", 32'(bus.rd_data[0]), 0);
    chk("rst_rd1", 32'(bus.rd_data[1]), 5);
    chk("rst_rd2", 32'(bus.rd_data[2]), 10);
    chk("rst_rd3", 32'(bus.rd_data[3]), 15);
    chk("rst_empty", 32'(bus.ckpt_empty), 1);
    chk("rst_full", 32'(bus.ckpt_full), 0);
    status("rst", 0, 0, 0);

    // same-address dual write, port1 wins
    setrd(3, 2, 1, 4);
    bus.wr_en      = 2'b11;
    bus.wr_addr[0] = 3;
    bus.wr_addr[1] = 3;
    bus.wr_data[0] = 20;
    bus.wr_data[1] = 21;
    #1;
    chk("wr_nobypass", 32'(bus.rd_data[0]), 3);
    tick();
    idle();
    chk("wr_port1_wins", 32'(bus.rd_data[0]), 21);

    // write r2->17 with save: snapshot sees write
    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 2;
    bus.wr_data[0] = 17;
    bus.ckpt_save  = 1'b1;
    tick();
    idle();
    chk("sv_r2", 32'(bus.rd_data[1]), 17);
    chk("sv_empty", 32'(bus.ckpt_empty), 0);
    status("sv", 1, 1, 0);

    bus.wr_en      = 2'b10;
    bus.wr_addr[1] = 2;
    bus.wr_data[1] = 25;
    tick();
    idle();
    chk("wr_r2_25", 32'(bus.rd_data[1]), 25);

    bus.ckpt_restore    = 1'b1;
    bus.ckpt_restore_id = 0;
    tick();
    idle();
    chk("rs0_r2", 32'(bus.rd_data[1]), 17);
    chk("rs0_r3", 32'(bus.rd_data[0]), 21);
    status("rs0", 0, 0, 0);

    // fill the ring
    bus.ckpt_save = 1'b1;
    repeat (4) tick();
    chk("fill_full", 32'(bus.ckpt_full), 1);
    status("fill", 4, 0, 0);
    tick();
    chk("drop_full", 32'(bus.ckpt_full), 1);
    status("drop", 4, 0, 0);
    bus.ckpt_free = 1'b1;
    tick();
    idle();
    status("svfree", 4, 1, 0);

    // restore beats write and save; head=1
    bus.ckpt_restore    = 1'b1;
    bus.ckpt_restore_id = 3;
    bus.wr_en           = 2'b01;
    bus.wr_addr[0]      = 1;
    bus.wr_data[0]      = 30;
    bus.ckpt_save       = 1'b1;
    tick();
    idle();
    chk("rs3_r1", 32'(bus.rd_data[2]), 1);
    chk("rs3_full", 32'(bus.ckpt_full), 0);
    status("rs3", 2, 3, 0);

    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 1;
    bus.wr_data[0] = 30;
    tick();
    idle();
    chk("wr_r1_30", 32'(bus.rd_data[2]), 30);

    bus.ckpt_free = 1'b1;
    tick();
    idle();
    status("free", 1, 3, 0);

    // id 1 was freed: not live
    bus.ckpt_restore    = 1'b1;
    bus.ckpt_restore_id = 1;
    tick();
    idle();
    chk("bad_r1", 32'(bus.rd_data[2]), 30);
    status("bad", 1, 3, 1);
    tick();
    chk("bad_pulse_end", 32'(bus.restore_err), 0);

    // restore to oldest + free: free has nothing left
    bus.ckpt_restore    = 1'b1;
    bus.ckpt_restore_id = 2;
    bus.ckpt_free       = 1'b1;
    tick();
    idle();
    chk("rsfr_r1", 32'(bus.rd_data[2]), 1);
    chk("rsfr_r3", 32'(bus.rd_data[0]), 21);
    chk("rsfr_empty", 32'(bus.ckpt_empty), 1);
    status("rsfr", 0, 2, 0);

    bus.ckpt_free = 1'b1;
    tick();
    idle();
    status("frempty", 0, 2, 1);

    // state then synchronous reset mid-sequence
    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 4;
    bus.wr_data[0] = 9;
    bus.ckpt_save  = 1'b1;
    tick();
    idle();
    chk("pre_rst_r4", 32'(bus.rd_data[3]), 9);
    status("pre_rst", 1, 3, 0);

    rst            = 1'b1;
    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 4;
    bus.wr_data[0] = 12;
    bus.ckpt_save  = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_r3", 32'(bus.rd_data[0]), 3);
    chk("rst2_r2", 32'(bus.rd_data[1]), 2);
    chk("rst2_r4", 32'(bus.rd_data[3]), 4);
    chk("rst2_empty", 32'(bus.ckpt_empty), 1);
    status("rst2", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_map_ckpt.md
Name: rename_map_ckpt

Overview:
- Parametrised register alias table for the out-of-order core. Maps architectural register numbers to physical register tags for RD_PORTS source lookups and WR_PORTS destination renames per cycle.
- Adds a circular buffer of NUM_CKPT snapshots for branch-misprediction recovery.
- Sits between decode/rename and the free list and ROB. Rename control drives writes; branch resolve drives checkpoint save, restore and free.

Parameters:
- NUM_ARCH, 16, architectural registers (power of 2); ARCH_W = $clog2(NUM_ARCH).
- NUM_PHYS, 32, physical registers (>= NUM_ARCH); PHYS_W = $clog2(NUM_PHYS).
- RD_PORTS, 4, combinational lookup ports.
- WR_PORTS, 2, rename write ports; a higher index is younger in program order.
- NUM_CKPT, 4, snapshot slots (power of 2); CK_W = $clog2(NUM_CKPT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  [RD_PORTS][ARCH_W]  lookup indices.
- rd_data  out  [RD_PORTS][PHYS_W]  current mappings.
- wr_en  in  [WR_PORTS]  rename write strobes.
- wr_addr  in  [WR_PORTS][ARCH_W]  destination architectural regs.
- wr_data  in  [WR_PORTS][PHYS_W]  new physical tags.
- ckpt_save  in  1  snapshot request.
- ckpt_save_id  out  CK_W  slot the next save uses (tail pointer).
- ckpt_restore  in  1  recover to a snapshot.
- ckpt_restore_id  in  CK_W  snapshot to recover.
- ckpt_free  in  1  release the oldest snapshot (branch resolved correctly).
- ckpt_count  out  CK_W+1  live snapshots.
- ckpt_full  out  1  ckpt_count == NUM_CKPT.
- ckpt_empty  out  1  ckpt_count == 0.
- restore_err  out  1  registered pulse: restore to a non-live id, or free while empty.

Behaviour:
- Reset (rst high at clk edge):
  - map[i] = i for all i.
  - head = tail = 0, count = 0.
  - restore_err = 0.
  - Snapshot contents are don't-care.
- Reads:
  - rd_data[p] = map[rd_addr[p]], combinational.
  - Reads show the pre-edge table. There is no same-cycle write bypass; intra-group dependencies are resolved by rename control.
- Writes:
  - Committed at the clk edge.
  - If several ports write the same wr_addr, the highest index wins.
- Save:
  - Accepted when ckpt_save && (!ckpt_full || ckpt_free).
  - The snapshot stored in slot tail is the table after this cycle's writes.
  - tail advances by 1 and wraps modulo NUM_CKPT; count increments.
  - A save while full without a free is dropped. restore_err is not raised; rename control must stall on ckpt_full.
- Free:
  - head advances by 1 and wraps; count decrements.
  - Free while empty is ignored and pulses restore_err.
- Restore:
  - Valid when id is live: the age (id - head) mod NUM_CKPT < count.
  - Next cycle, map = snapshot[id].
  - tail = id, which discards id and every younger snapshot; count = (id - head) mod NUM_CKPT.
  - A restore to a non-live id is ignored and restore_err pulses 1 for one cycle.
- Priority within one cycle:
  - rst over everything.
  - A valid restore overrides all wr_en and any ckpt_save; those are dropped.
  - Free and a valid restore together: restore is applied first, then free acts on the resulting count. If that count is 0, free is ignored and restore_err does not pulse.
  - Save and free together: both apply; count is unchanged.
- Latency:
  - A write or restore is visible on rd_data in the cycle after the edge.
  - ckpt_* status outputs are registered-state-derived.

Decomposition:
- Package rename_pkg holds:
  - localparams ARCH_W, PHYS_W, CK_W;
  - typedefs arch_t, phys_t, ckpt_id_t, map_t (array of phys_t).
- Sub-module ckpt_ring holds the head/tail/count pointer logic, the live-id check and the error pulse. The top level holds the map and the snapshot storage.

Test Plan:
- Reset, then read ports at 0,5,10,15 -> rd_data 0,5,10,15; ckpt_empty=1, count=0.
- wr_en=11, wr_addr={3,3}, wr_data={20,21} (port0=20, port1=21):
  - next cycle rd_addr=3 -> 21 (port1 wins);
  - same-cycle read still shows 3.
- Write r2->17, then save (id 0):
  - write r2->25 -> read 25;
  - restore id 0 -> next cycle read r2 = 17, count=0, save_id=0.
- Four saves -> ckpt_full=1; a fifth save without free -> count stays 4; save+free same cycle -> count 4, tail wraps to 1.
- Restore + wr_en (r1->30) + save in the same cycle -> r1 holds the snapshot value, not 30; count equals id's age.
- Restore to a freed id after free -> restore_err pulses 1 for one cycle, map unchanged. Then assert rst mid-sequence -> identity map, count 0.
